// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction-memory path: loader state encodings and
// the byte/word geometry also used by the instruction memory and PC logic.
package mips_pkg;

  localparam int unsigned INST_BYTES = 4;
  localparam int unsigned WORD_SHIFT = 2;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_RECV,
    LD_WRITE,
    LD_DONE
  } ld_state_e;

endpackage

// File: rtl/inst_mem_loader_if.sv
// Loader control, byte stream and instruction-memory write bus.
// master = host/stream side, slave = the loader.
interface inst_mem_loader_if #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
);

  logic             start;
  logic [CNT_W-1:0] num_words;
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic             wr_en;
  logic [31:0]      wr_addr;
  logic [31:0]      wr_data;
  logic             cpu_hold;
  logic             busy;
  logic             done;
  logic             error;

  modport master (
    output start, num_words, byte_in, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, error
  );

  modport slave (
    input  start, num_words, byte_in, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, error
  );

endinterface

// File: rtl/inst_mem_loader_byte_packer.sv
// Big-endian byte-to-word shift register: the first byte shifted in ends up in
// the top byte once the word is full.
module byte_packer
  import mips_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  shift_en,
  input  logic                  clear,
  input  logic [7:0]            byte_in,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_full
);

  logic [DATA_WIDTH-1:0] word_q;
  logic [1:0]            cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (shift_en) begin
      word_q <= {word_q[DATA_WIDTH-9:0], byte_in};
      cnt_q  <= cnt_q + 2'd1;
    end
  end

  // Asserted in the cycle the last byte of a word is being accepted.
  assign word_full = shift_en && (cnt_q == 2'(INST_BYTES - 1));
  assign word      = word_q;

endmodule

// File: rtl/inst_mem_loader.sv
// Loads a byte-streamed program into instruction memory as big-endian words at
// byte addresses 0, 4, 8, ... while holding the CPU in reset.
module inst_mem_loader
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_W      = $clog2(DEPTH) + 1
) (
  input logic              clk,
  input logic              reset,
  inst_mem_loader_if.slave bus
);

  localparam logic [CNT_W-1:0] MaxWords = CNT_W'(DEPTH);

  ld_state_e             state_q, state_d;
  logic [CNT_W-1:0]      num_words_q, word_idx_q;
  logic [DATA_WIDTH-1:0] wr_data_q, word;
  logic [31:0]           wr_addr_q, cur_addr;
  logic                  error_q, len_ok, start_ok, start_bad, accept, clear, word_full;

  assign len_ok    = (bus.num_words != '0) && (bus.num_words <= MaxWords);
  assign start_ok  = (state_q == LD_IDLE) && bus.start && len_ok;
  assign start_bad = (state_q == LD_IDLE) && bus.start && !len_ok;
  assign accept    = (state_q == LD_RECV) && bus.byte_valid;
  assign clear     = start_ok || (state_q == LD_WRITE);
  assign cur_addr  = 32'(word_idx_q) << WORD_SHIFT;

  byte_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (accept),
    .clear     (clear),
    .byte_in   (bus.byte_in),
    .word      (word),
    .word_full (word_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LD_IDLE:  if (start_ok) state_d = LD_RECV;
      LD_RECV:  if (word_full) state_d = LD_WRITE;
      LD_WRITE: state_d = (word_idx_q + CNT_W'(1) == num_words_q) ? LD_DONE : LD_RECV;
      LD_DONE:  state_d = LD_IDLE;
      default:  state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num_words_q <= '0;
      word_idx_q  <= '0;
      wr_data_q   <= '0;
      wr_addr_q   <= '0;
      error_q     <= 1'b0;
    end else begin
      error_q <= start_bad;
      if (start_ok) begin
        num_words_q <= bus.num_words;
        word_idx_q  <= '0;
      end else if (state_q == LD_WRITE) begin
        word_idx_q <= word_idx_q + CNT_W'(1);
        wr_data_q  <= word;
        wr_addr_q  <= cur_addr;
      end
    end
  end

  // Write bus shows the live word during WRITE and holds it afterwards.
  always_comb begin
    bus.byte_ready = (state_q == LD_RECV);
    bus.wr_en      = (state_q == LD_WRITE);
    bus.wr_data    = (state_q == LD_WRITE) ? word : wr_data_q;
    bus.wr_addr    = (state_q == LD_WRITE) ? cur_addr : wr_addr_q;
    bus.cpu_hold   = (state_q == LD_RECV) || (state_q == LD_WRITE);
    bus.busy       = (state_q != LD_IDLE);
    bus.done       = (state_q == LD_DONE);
    bus.error      = error_q;
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: directed and randomized loads checked
// against expected words computed from the byte stream.
module tb_inst_mem_loader;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned CNT_W = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  inst_mem_loader_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  inst_mem_loader #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (32),
    .CNT_W      (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Monitor state, written only by the monitor process.
  int cyc = 0, done_cnt = 0, err_cnt = 0, acc_cnt = 0, busy_cnt = 0, hold_viol = 0;
  int last_acc_cyc = 0, done_cyc = 0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  logic [7:0] stim [0:127];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.wr_en) begin
      wa_q.push_back(bus.wr_addr);
      wd_q.push_back(bus.wr_data);
    end
    if (bus.done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (bus.error) err_cnt <= err_cnt + 1;
    if (bus.byte_valid && bus.byte_ready) begin
      acc_cnt      <= acc_cnt + 1;
      last_acc_cyc <= cyc;
    end
    if (bus.busy || bus.cpu_hold || bus.wr_en) busy_cnt <= busy_cnt + 1;
    if ((bus.wr_en || bus.byte_ready) && !bus.cpu_hold) hold_viol <= hold_viol + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_flags"}, {26'd0, bus.byte_ready, bus.wr_en, bus.cpu_hold, bus.busy,
                          bus.done, bus.error}, 32'd0);
    chk({tag, "_addr"}, bus.wr_addr, 32'd0);
    chk({tag, "_data"}, bus.wr_data, 32'd0);
  endtask

  task automatic do_start(input int n);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.num_words = CNT_W'(n);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Entered and left at a negedge; returns once the byte has been taken.
  task automatic send_byte(input logic [7:0] b, input int max_idle, input string tag);
    int  idle;
    bit  ok;
    idle = (max_idle > 0) ? int'($urandom_range(max_idle, 0)) : 0;
    bus.byte_valid = 1'b0;
    repeat (idle) @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_in    = b;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      if (bus.byte_ready) ok = 1'b1;
      @(negedge clk);
    end
    bus.byte_valid = 1'b0;
    if (!ok) chk({tag, "_byte_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic fill_random(input int nbytes);
    for (int i = 0; i < nbytes; i++) stim[i] = 8'($urandom);
  endtask

  task automatic run_load(input int n, input int max_idle, input int inj_nw, input string tag);
    int wb, d0, e0, a0, hv0;
    wb  = wa_q.size();
    d0  = done_cnt;
    e0  = err_cnt;
    a0  = acc_cnt;
    hv0 = hold_viol;
    do_start(n);
    for (int i = 0; i < 4 * n; i++) begin
      if (inj_nw >= 0 && i == 2) begin
        bus.start     = 1'b1;
        bus.num_words = CNT_W'(inj_nw);
        @(negedge clk);
        bus.start = 1'b0;
      end
      // Byte after a full word goes out immediately so it lands in the WRITE cycle.
      send_byte(stim[i], (i % 4 == 0) ? 0 : max_idle, tag);
    end
    for (int k = 0; k < 20 && done_cnt == d0; k++) @(negedge clk);
    chk({tag, "_done_cnt"}, done_cnt - d0, 1);
    chk({tag, "_done_lat"}, done_cyc - last_acc_cyc, 2);
    chk({tag, "_hold_after"}, {30'd0, bus.cpu_hold, bus.busy}, 32'd0);
    chk({tag, "_nwrites"}, wa_q.size() - wb, n);
    chk({tag, "_naccept"}, acc_cnt - a0, 4 * n);
    chk({tag, "_err"}, err_cnt - e0, 0);
    chk({tag, "_hold_viol"}, hold_viol - hv0, 0);
    for (int i = 0; i < n && wb + i < wa_q.size(); i++) begin
      chk({tag, "_addr"}, wa_q[wb+i], 32'(4 * i));
      chk({tag, "_data"}, wd_q[wb+i], {stim[4*i], stim[4*i+1], stim[4*i+2], stim[4*i+3]});
    end
  endtask

  initial begin
    int wb, e0, b0;
    logic [31:0] t1 [0:1];
    bus.start      = 1'b0;
    bus.num_words  = '0;
    bus.byte_in    = '0;
    bus.byte_valid = 1'b0;

    #3 reset = 1'b0;
    #1 chk_idle_outputs("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Two-word load, no gaps.
    t1[0] = 32'h8C01_0004;
    t1[1] = 32'h8C22_0005;
    for (int i = 0; i < 8; i++) stim[i] = t1[i/4][31-8*(i%4) -: 8];
    run_load(2, 0, -1, "t1");
    chk("t1_w1_exact", wd_q[wd_q.size()-1], 32'h8C22_0005);

    // Same stream with gaps and a byte held through WRITE.
    run_load(2, 2, -1, "t2");

    // Rejected starts.
    for (int r = 0; r < 2; r++) begin
      e0 = err_cnt;
      b0 = busy_cnt;
      do_start(r == 0 ? 0 : 33);
      repeat (3) @(negedge clk);
      chk("t3_err_pulse", err_cnt - e0, 1);
      chk("t3_no_busy", busy_cnt - b0, 0);
    end

    // Full memory, word k = k,k,k,k.
    for (int i = 0; i < 128; i++) stim[i] = 8'(i / 4);
    run_load(32, 0, -1, "t4");
    chk("t4_last_addr", wa_q[wa_q.size()-1], 32'd124);
    chk("t4_last_data", wd_q[wd_q.size()-1], 32'h1F1F_1F1F);

    // Reset after 6 bytes of a 2-word load.
    fill_random(8);
    wb = wa_q.size();
    do_start(2);
    for (int i = 0; i < 6; i++) send_byte(stim[i], 1, "t5");
    #2 reset = 1'b0;
    #1 chk_idle_outputs("t5_async");
    chk("t5_nwrites", wa_q.size() - wb, 1);
    chk("t5_w0", wd_q[wb], {stim[0], stim[1], stim[2], stim[3]});
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5_no_partial", wa_q.size() - wb, 1);
    fill_random(4);
    run_load(1, 1, -1, "t5_reload");

    // Start while busy: neither re-latched nor flagged.
    fill_random(12);
    run_load(3, 1, 1, "t6");
    fill_random(12);
    run_load(3, 0, 0, "t6_zero");

    // Randomized loads.
    for (int r = 0; r < 6; r++) begin
      int n;
      n = int'($urandom_range(8, 1));
      fill_random(4 * n);
      run_load(n, 2, -1, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Writer side of the instruction memory: receives a program as a byte stream (from a UART/debug bridge) over a valid/ready handshake.
- Packs the bytes big-endian into 32-bit instruction words.
- Issues single-cycle word writes to the instruction memory at byte addresses 0, 4, 8, …, so the memory's address>>2 indexing lands on words 0, 1, 2, ….
- Holds the CPU in reset (cpu_hold) for the whole load.

Parameters:
- DEPTH, 32, instruction memory size in words; maximum loadable program length.
- DATA_WIDTH, 32, instruction word width. Fixed at 4 bytes; other values unsupported.
- CNT_W, $clog2(DEPTH)+1, width of word counters; holds values 0..DEPTH.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a load; sampled only in IDLE.
- num_words  in  CNT_W  program length in words; latched on an accepted start.
- byte_in  in  8  stream data byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader can accept a byte this cycle.
- wr_en  out  1  instruction-memory write strobe, one cycle per word.
- wr_addr  out  32  byte address of the write, equal to word_idx*4.
- wr_data  out  32  assembled instruction word.
- cpu_hold  out  1  high from an accepted start until DONE; the CPU is held in reset while high.
- busy  out  1  high when not IDLE.
- done  out  1  one-cycle pulse when the load completes.
- error  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs clear to 0: byte_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, error.
  - Byte counter and word index clear to 0.
  - Memory words already written are not reverted.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - start=1 with 1 <= num_words <= DEPTH: latch num_words, clear word_idx and byte_cnt, set cpu_hold=1, go to RECV.
  - start=1 with num_words==0 or num_words>DEPTH: error=1 for the next cycle only, stay IDLE, cpu_hold stays 0.
- RECV:
  - byte_ready=1.
  - Handshake: a byte is accepted only on a cycle with byte_valid && byte_ready; with byte_valid=0 nothing changes.
  - Accepted bytes are shifted in: 1st byte -> [31:24], 2nd -> [23:16], 3rd -> [15:8], 4th -> [7:0].
  - On the 4th accepted byte, go to WRITE; byte_ready drops the following cycle.
- WRITE (exactly one cycle):
  - wr_en=1, wr_data=assembled word, wr_addr=word_idx<<2, byte_ready=0.
  - A byte_valid in this cycle is not accepted and the source must hold it.
  - word_idx increments and byte_cnt resets.
  - If word_idx+1 == latched num_words, go to DONE; otherwise return to RECV.
- DONE (one cycle): done=1, cpu_hold=0, busy=0 next cycle, go to IDLE.
- start while busy is ignored, with no error pulse.
- Throughput: 4 bytes per 5 cycles at best (4 RECV + 1 WRITE).
- Latency: the last byte is accepted at cycle N, its write is at N+1, done at N+2.
- wr_data and wr_addr hold their last values outside WRITE; only wr_en qualifies them.
- Reset mid-load aborts immediately. Partial words are discarded; complete words stay in memory.

Decomposition:
- Shared package mips_pkg:
  - Loader state encodings LD_IDLE, LD_RECV, LD_WRITE, LD_DONE.
  - INST_BYTES=4 and WORD_SHIFT=2 (byte-to-word address shift), shared with the instruction memory and the PC logic.
- Sub-module byte_packer:
  - 32-bit shift register plus 2-bit byte counter.
  - Inputs: shift_en, clear.
  - Outputs: word, word_full.
  - The FSM stays in inst_mem_loader.

Test Plan:
1. Two-word load with no gaps:
   - Stimulus: start with num_words=2; bytes 8C 01 00 04 8C 22 00 05 with byte_valid held high.
   - Required: wr_en at addr 0 data 0x8C010004, then at addr 4 data 0x8C220005; done 2 cycles after the 8th byte; cpu_hold high throughout, low after done.
2. Backpressure and gaps:
   - Stimulus: same stream with byte_valid toggling 1/0 and a byte presented in the WRITE cycle.
   - Required: identical writes; the byte held during WRITE is accepted the next cycle and none are duplicated.
3. Rejected starts:
   - Stimulus: start with num_words=0, then start with num_words=33.
   - Required: error pulses for 1 cycle each; busy, cpu_hold and wr_en stay 0.
4. Full memory:
   - Stimulus: num_words=32 with byte pattern k,k,k,k for word k.
   - Required: 32 writes, the last at addr 124 with data 0x1F1F1F1F; done asserted once.
5. Reset mid-load:
   - Stimulus: assert reset after 6 bytes of a 2-word load.
   - Required: outputs go 0 asynchronously; no write for the partial 2nd word.
   - Follow-up: a new start loads from addr 0.
6. Start while busy:
   - Stimulus: pulse start during RECV.
   - Required: ignored; no error pulse, num_words is not re-latched, and the load completes as originally requested.
